// File: rtl/lifo_ctrl_arb_pkg.sv
// lifo_ctrl_arb_pkg: shared encodings for the LIFO controller/arbiter
package lifo_ctrl_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, EXEC = 2'd2, RESP = 2'd3} state_t;
  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP = 1'b0;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
  typedef struct packed {
    logic en;
    logic push_pop;
    logic w_en;
    logic rw;
    logic oe;
  } strb_t;
endpackage

// File: rtl/lifo_ctrl_arb_if.sv
// lifo_ctrl_arb_if: requester handshakes plus LIFO strobe/data bus
interface lifo_ctrl_arb_if #(parameter int DW = 8);
  logic          REQ_A, OP_A, ACK_A, ERR_A;
  logic [DW-1:0] DIN_A;
  logic          REQ_B, OP_B, ACK_B, ERR_B;
  logic [DW-1:0] DIN_B;
  logic [DW-1:0] DOUT;
  logic          BUSY, GNT;
  logic          LIFO_EN, LIFO_PUSH_POP, LIFO_W_EN, LIFO_RW, LIFO_OE;
  logic [DW-1:0] LIFO_WDATA, LIFO_RDATA;
  logic          LIFO_FULL, LIFO_EMPTY;
  modport slave (
    input  REQ_A, OP_A, DIN_A, REQ_B, OP_B, DIN_B, LIFO_RDATA, LIFO_FULL, LIFO_EMPTY,
    output ACK_A, ERR_A, ACK_B, ERR_B, DOUT, BUSY, GNT,
           LIFO_EN, LIFO_PUSH_POP, LIFO_W_EN, LIFO_RW, LIFO_OE, LIFO_WDATA
  );
  modport master (
    output REQ_A, OP_A, DIN_A, REQ_B, OP_B, DIN_B, LIFO_RDATA, LIFO_FULL, LIFO_EMPTY,
    input  ACK_A, ERR_A, ACK_B, ERR_B, DOUT, BUSY, GNT,
           LIFO_EN, LIFO_PUSH_POP, LIFO_W_EN, LIFO_RW, LIFO_OE, LIFO_WDATA
  );
endinterface

// File: rtl/lifo_ctrl_arb_rr_arb2.sv
// rr_arb2: two-way arbiter with a pointer that favours the side not granted last
module rr_arb2
  import lifo_ctrl_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic accept,
  input  logic fixed_prio,
  output logic win
);
  logic ptr_q, ptr_d;
  // winner selection and pointer flip on every accepted grant
  always_comb begin
    win = (req_a && req_b) ? (fixed_prio ? ID_A : ptr_q) : (req_b ? ID_B : ID_A);
    ptr_d = accept ? ~win : ptr_q;
  end
  // pointer register, starts on A
  always_ff @(posedge clk) begin
    ptr_q <= !rst_n ? ID_A : ptr_d;
  end
endmodule

// File: rtl/lifo_ctrl_arb.sv
// lifo_ctrl_arb: grants one of two requesters and sequences a shared 32x8 LIFO
module lifo_ctrl_arb
  import lifo_ctrl_arb_pkg::*;
#(
  parameter int DW = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic CLK,
  input logic RESET,
  lifo_ctrl_arb_if.slave bus
);
  state_t state_q, state_d;
  logic id_q, id_d, op_q, op_d, err_q, err_d, gnt_q, gnt_d;
  logic ack_a_q, ack_a_d, ack_b_q, ack_b_d, err_a_q, err_a_d, err_b_q, err_b_d;
  logic [DW-1:0] din_q, din_d, dout_q, dout_d;
  strb_t strb_q, strb_d;
  logic win, accept;
  rr_arb2 u_arb (
    .clk(CLK),
    .rst_n(RESET),
    .req_a(bus.REQ_A),
    .req_b(bus.REQ_B),
    .accept(accept),
    .fixed_prio(FIXED_PRIO),
    .win(win)
  );
  // next state, request latches and registered strobe/ack values
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    op_d = op_q;
    din_d = din_q;
    err_d = err_q;
    gnt_d = gnt_q;
    dout_d = dout_q;
    accept = 1'b0;
    unique case (state_q)
      IDLE: if (bus.REQ_A || bus.REQ_B) begin
        accept = 1'b1;
        id_d = win;
        op_d = (win == ID_B) ? bus.OP_B : bus.OP_A;
        din_d = (win == ID_B) ? bus.DIN_B : bus.DIN_A;
        gnt_d = win;
        err_d = 1'b0;
        state_d = ARB;
      end
      ARB: begin
        err_d = (op_q == OP_PUSH) ? bus.LIFO_FULL : bus.LIFO_EMPTY;
        state_d = err_d ? RESP : EXEC;
      end
      EXEC: begin
        dout_d = (op_q == OP_POP) ? bus.LIFO_RDATA : dout_q;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    strb_d = (state_d == EXEC) ? strb_t'{en: 1'b1, push_pop: op_d, w_en: op_d, rw: ~op_d, oe: op_d} : '0;
    ack_a_d = (state_d == RESP) && (id_d == ID_A);
    ack_b_d = (state_d == RESP) && (id_d == ID_B);
    err_a_d = ack_a_d && err_d;
    err_b_d = ack_b_d && err_d;
  end
  // state and output registers; reset abandons any operation in flight
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      id_q <= ID_A;
      op_q <= OP_POP;
      din_q <= '0;
      err_q <= 1'b0;
      gnt_q <= ID_A;
      dout_q <= '0;
      strb_q <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      op_q <= op_d;
      din_q <= din_d;
      err_q <= err_d;
      gnt_q <= gnt_d;
      dout_q <= dout_d;
      strb_q <= strb_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      err_a_q <= err_a_d;
      err_b_q <= err_b_d;
    end
  end
  assign bus.ACK_A = ack_a_q;
  assign bus.ERR_A = err_a_q;
  assign bus.ACK_B = ack_b_q;
  assign bus.ERR_B = err_b_q;
  assign bus.DOUT = dout_q;
  assign bus.BUSY = state_q != IDLE;
  assign bus.GNT = gnt_q;
  assign bus.LIFO_EN = strb_q.en;
  assign bus.LIFO_PUSH_POP = strb_q.push_pop;
  assign bus.LIFO_W_EN = strb_q.w_en;
  assign bus.LIFO_RW = strb_q.rw;
  assign bus.LIFO_OE = strb_q.oe;
  assign bus.LIFO_WDATA = din_q;
endmodule

// File: tb/tb_lifo_ctrl_arb.sv
// tb_lifo_ctrl_arb: directed checks of the LIFO controller/arbiter against a stack model
module tb_lifo_ctrl_arb;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  logic ovl_seen = 1'b0;
  logic [7:0] mem [32];
  logic [5:0] cnt = '0;
  logic [5:0] cm1;
  always #5 CLK = ~CLK;
  lifo_ctrl_arb_if #(.DW(8)) bus ();
  lifo_ctrl_arb_if #(.DW(8)) bus1 ();
  lifo_ctrl_arb #(.DW(8), .FIXED_PRIO(1'b0)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  lifo_ctrl_arb #(.DW(8), .FIXED_PRIO(1'b1)) dut_fp (.CLK(CLK), .RESET(RESET), .bus(bus1));
  // behavioural 32-deep stack, cleared by the same reset
  always @(posedge CLK) begin
    if (!RESET) cnt <= '0;
    else if (bus.LIFO_EN) begin
      if (bus.LIFO_PUSH_POP && bus.LIFO_W_EN) begin
        mem[cnt[4:0]] <= bus.LIFO_WDATA;
        cnt <= cnt + 6'd1;
      end else cnt <= cnt - 6'd1;
    end
  end
  assign cm1 = cnt - 6'd1;
  assign bus.LIFO_RDATA = (cnt == 6'd0) ? 8'h00 : mem[cm1[4:0]];
  assign bus.LIFO_FULL = cnt == 6'd32;
  assign bus.LIFO_EMPTY = cnt == 6'd0;
  assign bus1.LIFO_RDATA = 8'h00;
  assign bus1.LIFO_FULL = 1'b0;
  assign bus1.LIFO_EMPTY = 1'b0;
  // strobe activity and OE/RW overlap monitor
  always @(posedge CLK) begin
    if (bus.LIFO_EN) en_cnt <= en_cnt + 1;
    if (bus.LIFO_OE && bus.LIFO_RW) ovl_seen <= 1'b1;
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    logic [26:0] v;
    v = {bus.ACK_A, bus.ERR_A, bus.ACK_B, bus.ERR_B, bus.BUSY, bus.GNT, bus.LIFO_EN,
         bus.LIFO_PUSH_POP, bus.LIFO_W_EN, bus.LIFO_RW, bus.LIFO_OE, bus.DOUT, bus.LIFO_WDATA};
    return 32'(v);
  endfunction
  task automatic do_op(input logic side, input logic op, input logic [7:0] din,
                       output logic err, output logic [7:0] dout, output int lat);
    lat = 0;
    if (side) begin
      bus.REQ_B = 1'b1; bus.OP_B = op; bus.DIN_B = din;
    end else begin
      bus.REQ_A = 1'b1; bus.OP_A = op; bus.DIN_A = din;
    end
    do begin
      tick();
      lat++;
    end while (!(side ? bus.ACK_B : bus.ACK_A) && lat < 8);
    err = side ? bus.ERR_B : bus.ERR_A;
    dout = bus.DOUT;
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
    tick();
  endtask
  task automatic op_chk(input string tag, input logic side, input logic op, input logic [7:0] din,
                        input logic exp_err, input logic [7:0] exp_dout, input bit chk_dout);
    logic err;
    logic [7:0] dout;
    int lat;
    do_op(side, op, din, err, dout, lat);
    chk({tag, "_lat"}, lat, exp_err ? 2 : 3);
    chk({tag, "_err"}, err, exp_err);
    if (chk_dout) chk({tag, "_dout"}, dout, exp_dout);
  endtask
  initial begin
    int n;
    int en_snap;
    bus.REQ_A = 0; bus.OP_A = 0; bus.DIN_A = 0;
    bus.REQ_B = 0; bus.OP_B = 0; bus.DIN_B = 0;
    bus1.REQ_A = 0; bus1.OP_A = 0; bus1.DIN_A = 0;
    bus1.REQ_B = 0; bus1.OP_B = 0; bus1.DIN_B = 0;
    tick();
    chk("rst_outs0", outs(), 0);
    tick();
    chk("rst_outs1", outs(), 0);
    chk("rst_no_en", en_cnt, 0);
    RESET = 1'b1;
    bus.REQ_A = 1; bus.OP_A = 1; bus.DIN_A = 8'h5A;
    tick();
    chk("t1_arb_busy", bus.BUSY, 1);
    chk("t1_arb_en", bus.LIFO_EN, 0);
    chk("t1_arb_gnt", bus.GNT, 0);
    bus.DIN_A = 8'hFF; bus.OP_A = 0;
    tick();
    chk("t1_exec_strb", {bus.LIFO_EN, bus.LIFO_PUSH_POP, bus.LIFO_W_EN, bus.LIFO_RW, bus.LIFO_OE}, 5'b11101);
    chk("t1_exec_wdata", bus.LIFO_WDATA, 8'h5A);
    tick();
    chk("t1_ack", bus.ACK_A, 1);
    chk("t1_err", bus.ERR_A, 0);
    chk("t1_resp_en", bus.LIFO_EN, 0);
    chk("t1_count", cnt, 1);
    bus.REQ_A = 0;
    tick();
    chk("t1_ack_drop", bus.ACK_A, 0);
    chk("t1_idle", bus.BUSY, 0);
    chk("t1_en_cycles", en_cnt, 1);
    op_chk("pop5a", 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b1);
    op_chk("push11", 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    op_chk("popb11", 1'b1, 1'b0, 8'h00, 1'b0, 8'h11, 1'b1);
    chk("empty_after_b", bus.LIFO_EMPTY, 1);
    bus.OP_A = 1; bus.DIN_A = 8'hA0; bus.OP_B = 1; bus.DIN_B = 8'hB0;
    bus1.OP_A = 1; bus1.DIN_A = 8'hA1; bus1.OP_B = 1; bus1.DIN_B = 8'hB1;
    bus.REQ_A = 1; bus.REQ_B = 1; bus1.REQ_A = 1; bus1.REQ_B = 1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!(bus.ACK_A || bus.ACK_B) && n < 8);
      chk("rr_gnt", bus.GNT, i % 2);
      chk("rr_ack_b", bus.ACK_B, i % 2);
      chk("fp_ack_a", bus1.ACK_A, 1);
      chk("rr_gap", n, (i == 0) ? 3 : 4);
      if (i == 3) begin
        bus.REQ_A = 0; bus.REQ_B = 0; bus1.REQ_A = 0;
      end
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus1.ACK_B && n < 8);
    chk("fp_b_after_a_drops", n, 4);
    chk("fp_gnt_b", bus1.GNT, 1);
    bus1.REQ_B = 0;
    tick();
    op_chk("rr_pop0", 1'b0, 1'b0, 8'h00, 1'b0, 8'hB0, 1'b1);
    op_chk("rr_pop1", 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 1'b1);
    op_chk("rr_pop2", 1'b0, 1'b0, 8'h00, 1'b0, 8'hB0, 1'b1);
    op_chk("rr_pop3", 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 1'b1);
    en_snap = en_cnt;
    op_chk("pop_empty", 1'b0, 1'b0, 8'h00, 1'b1, 8'hA0, 1'b1);
    chk("pop_empty_no_en", en_cnt, en_snap);
    for (int i = 0; i < 32; i++) op_chk("fill", 1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
    chk("full_flag", bus.LIFO_FULL, 1);
    en_snap = en_cnt;
    op_chk("push_full", 1'b1, 1'b1, 8'hEE, 1'b1, 8'hA0, 1'b1);
    chk("push_full_no_en", en_cnt, en_snap);
    for (int i = 31; i >= 0; i--) op_chk("drain", 1'b1, 1'b0, 8'h00, 1'b0, 8'(i), 1'b1);
    op_chk("pop_33", 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    chk("empty_flag", bus.LIFO_EMPTY, 1);
    bus.REQ_A = 1; bus.OP_A = 1; bus.DIN_A = 8'h77;
    tick();
    tick();
    chk("rst_exec_en", bus.LIFO_EN, 1);
    RESET = 1'b0;
    bus.REQ_A = 0;
    tick();
    chk("rst_mid_outs", outs(), 0);
    RESET = 1'b1;
    tick();
    tick();
    chk("rst_mid_no_ack", {bus.ACK_A, bus.BUSY}, 0);
    op_chk("post_rst_push", 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    op_chk("post_rst_pop", 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1);
    chk("oe_rw_overlap", ovl_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lifo_ctrl_arb.md
Name: lifo_ctrl_arb

Overview:
Two-requester controller/arbiter that shares one 32x8 LIFO stack (counter + RAM + full/empty logic) between ports A and B. It grants one requester at a time and sequences the stack strobes (EN, PUSH_POP, W_EN, RW) and the write-data tri-state enable. Pops are returned on DOUT, and illegal operations (push when full, pop when empty) are rejected without touching the stack. It sits between the client blocks and the LIFO top level; the LIFO's bidirectional IO bus is resolved at the top using LIFO_OE.

Parameters:
DW, 8, data width; must match the LIFO IO width.
FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins when both request.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  synchronous, active-low reset.
REQ_A  in  1  request from A; held high until ACK_A.
OP_A  in  1  1 = push, 0 = pop.
DIN_A  in  DW  push data from A.
ACK_A  out  1  one-cycle completion pulse to A.
ERR_A  out  1  valid with ACK_A; 1 = operation rejected.
REQ_B, OP_B, DIN_B, ACK_B, ERR_B  same as the A signals, for requester B.
DOUT  out  DW  pop data; valid in the ACK cycle of a successful pop, held until the next pop.
BUSY  out  1  high in any state other than IDLE.
GNT  out  1  current/last grant: 0 = A, 1 = B.
LIFO_EN, LIFO_PUSH_POP, LIFO_W_EN, LIFO_RW  out  1 each  stack strobes.
LIFO_WDATA  out  DW  data driven onto the LIFO IO bus.
LIFO_OE  out  1  top-level tri-state enable for LIFO_WDATA.
LIFO_RDATA  in  DW  LIFO IO bus readback.
LIFO_FULL, LIFO_EMPTY  in  1 each  stack flags.

Behaviour:
- Reset (RESET == 0 at a rising edge):
  - state goes to IDLE; priority pointer goes to A.
  - All outputs go to 0: ACK/ERR, DOUT, BUSY, GNT, all LIFO_* strobes, LIFO_WDATA, LIFO_OE.
  - Reset mid-operation abandons the operation with no ACK. Strobes are 0 from the next cycle on.
- FSM states: IDLE, ARB, EXEC, RESP.
  - IDLE: on an edge where REQ_A or REQ_B is high, latch the winner's ID, OP and DIN, set GNT, and go to ARB.
  - Winner selection: if only one requests, it wins. If both request, round-robin picks the side the pointer designates (FIXED_PRIO=1: always A).
  - The pointer flips to the non-granted side after every grant, including rejected ones.
  - ARB: sample LIFO_FULL/LIFO_EMPTY. These are stable because no operation is in flight.
    - Push with FULL=1, or pop with EMPTY=1: set err and go to RESP.
    - Otherwise go to EXEC.
  - EXEC (exactly one cycle), with LIFO_EN=1:
    - Push: LIFO_PUSH_POP=1, LIFO_W_EN=1, LIFO_RW=0, LIFO_OE=1, LIFO_WDATA = latched DIN. The stack writes at TOP and increments at the closing edge.
    - Pop: LIFO_PUSH_POP=0, LIFO_W_EN=0, LIFO_RW=1, LIFO_OE=0. DOUT captures LIFO_RDATA (address TOP-1) at the closing edge, while the stack decrements.
    - Next state: RESP.
  - RESP: ACK of the granted side = 1 for one cycle and ERR = err. Next state: IDLE.
- Strobes are registered outputs and are high only in EXEC. LIFO_OE never overlaps LIFO_RW=1.
- Latency, counted from the IDLE edge that samples REQ:
  - normal op: ACK 3 cycles later.
  - rejected op: ACK 2 cycles later.
  - back-to-back minimum: one operation per 4 cycles.
- Requesters drop REQ in the cycle after ACK. A REQ still high in IDLE is treated as a new request.
- Simultaneous push from A and pop from B: arbitration order only; the loser waits a full sequence.
- REQ, OP and DIN changes after the grant are ignored (latched values are used).
- Stack depth boundaries (count 0, 31, 32) are enforced solely via the flags.
  - Push when FULL → ERR.
  - Pop when EMPTY → ERR; DOUT unchanged.

Decomposition:
- Shared package: FSM state encodings (2-bit), OP_PUSH=1 / OP_POP=0, ID_A=0 / ID_B=1.
- One sub-module, rr_arb2: 2-input arbiter holding the priority pointer. Inputs: REQ_A, REQ_B, grant-accept strobe, FIXED_PRIO. Outputs: winner ID.
- FSM and datapath latches stay in lifo_ctrl_arb.

Test Plan:
- Reset with RESET=0 for 2 cycles, then REQ_A=1 push 0x5A → no strobes during reset; LIFO_EN high exactly in cycle 2; ACK_A in cycle 3, ERR_A=0; stack count 1.
- A pushes 0x11, then B pops → DOUT=0x11 in the ACK_B cycle, ERR_B=0; EMPTY=1 afterwards.
- REQ_A and REQ_B both held high, both pushing, over 4 operations → grant order A, B, A, B. With FIXED_PRIO=1 → A, A, A, A until REQ_A drops.
- Pop on empty stack → ACK_A with ERR_A=1, 2 cycles after request; LIFO_EN never asserted; DOUT unchanged.
- 32 pushes, then a 33rd push → the 33rd returns ERR=1. Then 32 pops return data in reverse order (31..0), and a 33rd pop returns ERR=1.
- RESET=0 asserted during EXEC of a push → next cycle: all outputs 0, state IDLE, no ACK; a new request then completes normally.
